mem_access_ctrl: RTL and testbench

Load/store initiator that drives the single-port data memory on behalf of the pipeline's memory stage. It accepts one request at a time over a valid/ready handshake and converts byte addresses to word indices. It issues single-cycle edge strobes (`mem_read`/`mem_write`) that the edge-triggered memory responds to, handles byte/halfword accesses (sign/zero-extended loads, read-modify-write stores), and returns the result over a valid/ready response channel.

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_access_ctrl_lane.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and request-legality helper for the memory access controller.
// Sub-word (byte/halfword) support is enabled by defining MEM_SUBWORD_EN.
package mem_ctrl_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_BITS  = WORD_BYTES * 8;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } mem_state_e;

    // True when the access size cannot be honoured at this byte offset.
    function automatic logic misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = addr_lo[0];
            WORD:    bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Byte-lane alignment: extracts and extends sub-word loads, merges sub-word stores.
// Instantiated by mem_access_ctrl only when MEM_SUBWORD_EN is defined.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]           shamt;
    logic [WORD_BITS-1:0] shifted;
    logic [WORD_BITS-1:0] mask;
    logic                 sign;

    assign shamt = {addr_lo, 3'b000};

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    always_comb begin
        shifted   = word >> shamt;
        mask      = '1;
        sign      = 1'b0;
        load_data = word;
        case (mem_size_e'(size))
            BYTE: begin
                sign      = ~is_unsigned & shifted[7];
                load_data = {{24{sign}}, shifted[7:0]};
                mask      = 32'h0000_00FF << shamt;
            end
            HALF: begin
                sign      = ~is_unsigned & shifted[15];
                load_data = {{16{sign}}, shifted[15:0]};
                mask      = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase
        merged = (word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the edge-triggered single-port data memory.
// Define MEM_SUBWORD_EN to enable byte/halfword loads and read-modify-write stores.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    mem_state_e state_q, state_d;
    mem_size_e  size_in;
    logic       accept;
    logic       req_err;

    assign size_in = mem_size_e'(req_size);
    assign accept  = req_valid && req_ready;

    always_comb begin
`ifdef MEM_SUBWORD_EN
        req_err = misaligned(size_in, req_addr[1:0]);
`else
        req_err = (size_in != WORD) || (req_addr[1:0] != 2'b00);
`endif
        if (req_addr[31:2] >= WORD_LIMIT) req_err = 1'b1;
    end

`ifdef MEM_SUBWORD_EN
    logic        write_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged;

    mem_lane_align u_lane (
        .word        (mem_rdata),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            addr_lo_q  <= 2'b00;
            wdata_q    <= '0;
        end else if (accept) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            addr_lo_q  <= req_addr[1:0];
            wdata_q    <= req_wdata;
        end
    end
`else
    logic unused_sub;
    assign unused_sub = req_unsigned;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)             state_d = RESP;
                    else if (!req_write)     state_d = RD;
                    else if (size_in == WORD) state_d = WR;
                    else                     state_d = RD;
                end
            end
`ifdef MEM_SUBWORD_EN
            RD:      state_d = write_q ? WR : RESP;
`else
            RD:      state_d = RESP;
`endif
            WR:      state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags and strobes are decoded from the next state into flops,
    // so the memory sees clean single-cycle pulses that reset clears at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            req_ready  <= (state_d == IDLE);
            resp_valid <= (state_d == RESP);
            mem_read   <= (state_d == RD);
            mem_write  <= (state_d == WR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            mem_addr   <= {2'b00, req_addr[31:2]};
            mem_wdata  <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= req_err;
        end else if (state_q == RD) begin
`ifdef MEM_SUBWORD_EN
            if (write_q) mem_wdata  <= merged;
            else         resp_rdata <= load_data;
`else
            resp_rdata <= mem_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with an edge-triggered memory model.
// Sub-word expectations follow MEM_SUBWORD_EN as defined for the build.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:1023];
    int          rd_edges = 0;
    int          wr_edges = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    mem_access_ctrl #(.MEM_WORDS(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge mem_read) begin
        rd_edges++;
        #1 mem_rdata = mem[mem_addr[9:0]];
    end

    always @(posedge mem_write) begin
        wr_edges++;
        #1 mem[mem_addr[9:0]] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = error (no strobe), 1 = single strobe, 2 = read-modify-write.
    task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input int kind,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
        int r0, w0;
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        if (hold > 0) resp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        if (kind == 2) begin
            check({tag, ".rmw_rd"}, {30'd0, mem_read, mem_write}, 32'd2);
            check({tag, ".rmw_addr"}, mem_addr, a >> 2);
            step();
        end
        if (kind >= 1) begin
            check({tag, ".strobe"}, {30'd0, mem_read, mem_write}, w ? 32'd1 : 32'd2);
            check({tag, ".addr"}, mem_addr, a >> 2);
            check({tag, ".early_valid"}, {31'd0, resp_valid}, 32'd0);
            if (w) check({tag, ".wdata"}, mem_wdata, exp_wd);
            step();
        end
        r0 = rd_edges; w0 = wr_edges;
        check({tag, ".resp"}, {29'd0, resp_valid, mem_read, mem_write}, 32'd4);
        check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, ".rdata"}, resp_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, ".held_valid"}, {30'd0, resp_valid, req_ready}, 32'd2);
            check({tag, ".held_rdata"}, resp_rdata, exp_rd);
            check({tag, ".held_addr"}, mem_addr, a >> 2);
        end
        if (hold > 0) begin
            check({tag, ".held_strobes"}, rd_edges + wr_edges, r0 + w0);
            resp_ready = 1'b1;
        end
        step();
        check({tag, ".done"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst.ctl", {28'd0, req_ready, resp_valid, mem_read, mem_write}, 32'd0);
        check("rst.err", {31'd0, resp_err}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        check("rst.wdata", mem_wdata, 32'd0);
        step(); step();
        #5 rst_n = 1'b1;
        step(); step();
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.no_edge", rd_edges + wr_edges, 32'd0);

        xact("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        check("st_word.one_edge", wr_edges, 32'd1);
        xact("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0, 32'hDEADBEEF, 1'b0, 0);

`ifdef MEM_SUBWORD_EN
        xact("ld_sb", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1, 32'h0, 32'hFFFFFFBE, 1'b0, 0);
        xact("ld_ub", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1, 32'h0, 32'h000000BE, 1'b0, 0);
        xact("ld_sh", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
        xact("ld_uh", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1, 32'h0, 32'h0000DEAD, 1'b0, 0);
        xact("st_byte", 1'b1, 2'b00, 1'b0, 32'h13, 32'h55, 2, 32'h55ADBEEF, 32'h0, 1'b0, 0);
        xact("ld_after_sb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0, 32'h55ADBEEF, 1'b0, 0);
        xact("st_half", 1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, 2, 32'h55AD1234, 32'h0, 1'b0, 0);
        xact("ld_after_sh", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0, 32'h55AD1234, 1'b0, 0);
`else
        xact("ld_sb_off", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, 32'h0, 32'h0, 1'b1, 0);
        xact("ld_sh_off", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 32'h0, 32'h0, 1'b1, 0);
        xact("st_byte_off", 1'b1, 2'b00, 1'b0, 32'h13, 32'h55, 0, 32'h0, 32'h0, 1'b1, 0);
        xact("ld_unchanged", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0, 32'hDEADBEEF, 1'b0, 0);
`endif

        xact("err_word_06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 32'h0, 32'h0, 1'b1, 0);
        xact("err_half_13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0, 32'h0, 32'h0, 1'b1, 0);
        xact("err_rsvd", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 32'h0, 32'h0, 1'b1, 0);
        xact("err_range", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h1, 0, 32'h0, 32'h0, 1'b1, 0);
        xact("last_word", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A, 32'h0, 1'b0, 0);
        xact("ld_last", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 1, 32'h0, 32'hA5A5_5A5A, 1'b0, 0);

`ifdef MEM_SUBWORD_EN
        xact("bp_load", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0, 32'h55AD1234, 1'b0, 3);
`else
        xact("bp_load", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0, 32'hDEADBEEF, 1'b0, 3);
`endif
        xact("bp_err", 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 0, 32'h0, 32'h0, 1'b1, 3);

        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        step();
        req_valid = 1'b0;
        check("rst_rd.in_rd", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_rd.read_drop", {29'd0, mem_read, mem_write, resp_valid}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("rst_rd.idle", {29'd0, req_ready, resp_valid, mem_read}, 32'd4);
        step();
        check("rst_rd.no_resp", {29'd0, req_ready, resp_valid, mem_write}, 32'd4);
        xact("post_rst", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 1, 32'h0, 32'hA5A5_5A5A, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
